// File: rtl/miriscv_alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for miriscv_alu_arbiter.
// The slave modport is the arbiter's view; master is the requesters/ALU side.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

interface miriscv_alu_arbiter_if;
    logic                     req0_valid_i;
    logic                     req0_ready_o;
    logic [`ALU_OP_WIDTH-1:0] req0_op_i;
    logic [31:0]              req0_a_i;
    logic [31:0]              req0_b_i;
    logic                     rsp0_valid_o;
    logic                     rsp0_ready_i;
    logic [31:0]              rsp0_result_o;
    logic                     rsp0_flag_o;

    logic                     req1_valid_i;
    logic                     req1_ready_o;
    logic [`ALU_OP_WIDTH-1:0] req1_op_i;
    logic [31:0]              req1_a_i;
    logic [31:0]              req1_b_i;
    logic                     rsp1_valid_o;
    logic                     rsp1_ready_i;
    logic [31:0]              rsp1_result_o;
    logic                     rsp1_flag_o;

    logic [`ALU_OP_WIDTH-1:0] alu_operator_o;
    logic [31:0]              alu_operand_a_o;
    logic [31:0]              alu_operand_b_o;
    logic [31:0]              alu_result_i;
    logic                     alu_flag_i;

    modport slave (
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i, rsp0_ready_i,
        output req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_flag_o,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i, rsp1_ready_i,
        output req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_flag_o,
        output alu_operator_o, alu_operand_a_o, alu_operand_b_o,
        input  alu_result_i, alu_flag_i
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i, rsp0_ready_i,
        input  req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_flag_o,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i, rsp1_ready_i,
        input  req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_flag_o,
        input  alu_operator_o, alu_operand_a_o, alu_operand_b_o,
        output alu_result_i, alu_flag_i
    );
endinterface

// File: rtl/miriscv_alu_arbiter.sv
// Round-robin sharing of one external ALU between two requesters via an operand
// stage (S1) and a response stage (S2). Optional counters: MIRISCV_ALU_ARB_STATS_EN.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

module miriscv_alu_arbiter #(
    parameter logic RR_RESET_PTR = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef MIRISCV_ALU_ARB_STATS_EN
    output logic [31:0] grant0_cnt_o,
    output logic [31:0] grant1_cnt_o,
    output logic [31:0] stall_cnt_o,
`endif
    miriscv_alu_arbiter_if.slave bus
);
    logic                     s1_valid_r;
    logic                     s1_owner_r;
    logic [`ALU_OP_WIDTH-1:0] s1_op_r;
    logic [31:0]              s1_a_r;
    logic [31:0]              s1_b_r;
    logic                     s2_valid_r;
    logic                     s2_owner_r;
    logic [31:0]              s2_result_r;
    logic                     s2_flag_r;
    logic                     ptr_r;

    logic s2_fire_s, s1_adv_s, s1_free_s, grant0_s, grant1_s;

    assign s2_fire_s = s2_valid_r & (s2_owner_r ? bus.rsp1_ready_i : bus.rsp0_ready_i);
    assign s1_adv_s  = s1_valid_r & (~s2_valid_r | s2_fire_s);
    assign s1_free_s = ~s1_valid_r | s1_adv_s;

    // Round-robin grant; only when S1 can take a new operation and not in reset.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst_i || !s1_free_s) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (bus.req0_valid_i && bus.req1_valid_i) begin
            grant0_s = ~ptr_r;
            grant1_s = ptr_r;
        end else if (bus.req0_valid_i) begin
            grant0_s = 1'b1;
        end else if (bus.req1_valid_i) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign bus.req0_ready_o = grant0_s;
    assign bus.req1_ready_o = grant1_s;

    // Drive the ALU from S1; all-zero while the operand stage is empty.
    always_comb begin
        bus.alu_operator_o  = {`ALU_OP_WIDTH{1'b0}};
        bus.alu_operand_a_o = 32'd0;
        bus.alu_operand_b_o = 32'd0;
        if (s1_valid_r) begin
            bus.alu_operator_o  = s1_op_r;
            bus.alu_operand_a_o = s1_a_r;
            bus.alu_operand_b_o = s1_b_r;
        end else begin
            bus.alu_operator_o  = {`ALU_OP_WIDTH{1'b0}};
        end
    end

    // Route the S2 result to its owner only; the other port reads zero.
    always_comb begin
        bus.rsp0_valid_o  = s2_valid_r & ~s2_owner_r;
        bus.rsp1_valid_o  = s2_valid_r & s2_owner_r;
        bus.rsp0_result_o = (s2_valid_r & ~s2_owner_r) ? s2_result_r : 32'd0;
        bus.rsp0_flag_o   = s2_valid_r & ~s2_owner_r & s2_flag_r;
        bus.rsp1_result_o = (s2_valid_r & s2_owner_r) ? s2_result_r : 32'd0;
        bus.rsp1_flag_o   = s2_valid_r & s2_owner_r & s2_flag_r;
    end

    // Pipeline and pointer update; reset discards anything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_r  <= 1'b0;
            s1_owner_r  <= 1'b0;
            s1_op_r     <= {`ALU_OP_WIDTH{1'b0}};
            s1_a_r      <= 32'd0;
            s1_b_r      <= 32'd0;
            s2_valid_r  <= 1'b0;
            s2_owner_r  <= 1'b0;
            s2_result_r <= 32'd0;
            s2_flag_r   <= 1'b0;
            ptr_r       <= RR_RESET_PTR;
        end else begin
            if (grant0_s || grant1_s) begin
                s1_valid_r <= 1'b1;
                s1_owner_r <= grant1_s;
                s1_op_r    <= grant1_s ? bus.req1_op_i : bus.req0_op_i;
                s1_a_r     <= grant1_s ? bus.req1_a_i  : bus.req0_a_i;
                s1_b_r     <= grant1_s ? bus.req1_b_i  : bus.req0_b_i;
                ptr_r      <= grant0_s;
            end else if (s1_adv_s) begin
                s1_valid_r <= 1'b0;
            end
            if (s1_adv_s) begin
                s2_valid_r  <= 1'b1;
                s2_owner_r  <= s1_owner_r;
                s2_result_r <= bus.alu_result_i;
                s2_flag_r   <= bus.alu_flag_i;
            end else if (s2_fire_s) begin
                s2_valid_r <= 1'b0;
            end
        end
    end

`ifdef MIRISCV_ALU_ARB_STATS_EN
    logic [31:0] grant0_cnt_r, grant1_cnt_r, stall_cnt_r;
    logic        stall_s;

    assign stall_s = (bus.req0_valid_i | bus.req1_valid_i) & ~(grant0_s | grant1_s);

    // Free-running wrap-around event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant0_cnt_r <= 32'd0;
            grant1_cnt_r <= 32'd0;
            stall_cnt_r  <= 32'd0;
        end else begin
            if (grant0_s) grant0_cnt_r <= grant0_cnt_r + 32'd1;
            if (grant1_s) grant1_cnt_r <= grant1_cnt_r + 32'd1;
            if (stall_s)  stall_cnt_r  <= stall_cnt_r + 32'd1;
        end
    end

    assign grant0_cnt_o = grant0_cnt_r;
    assign grant1_cnt_o = grant1_cnt_r;
    assign stall_cnt_o  = stall_cnt_r;
`endif
endmodule

// File: doc/miriscv_alu_arbiter.md
Name: miriscv_alu_arbiter

Overview:
- Shares one combinational ALU (`miriscv_alu`) between two requesters, e.g. the execute stage (port 0) and the branch/address unit (port 1).
- Round-robin arbitration with valid/ready handshakes on the request and response sides.
- Two-stage pipeline: operand register, then response register. The ALU sits between the two stages and is instantiated outside this block, connected through the alu_* ports.

Parameters:
- RR_RESET_PTR, 0, requester favoured first after reset (0 or 1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req0_valid_i  in  1  requester 0 request valid.
- req0_ready_o  out  1  requester 0 request accepted this cycle.
- req0_op_i  in  `ALU_OP_WIDTH  operation code (`ALU_* from miriscv_defines.v).
- req0_a_i  in  32  operand A.
- req0_b_i  in  32  operand B.
- rsp0_valid_o  out  1  result valid for requester 0.
- rsp0_ready_i  in  1  requester 0 consumes the result.
- rsp0_result_o  out  32  ALU result.
- rsp0_flag_o  out  1  ALU comparison flag.
- req1_* / rsp1_*: identical set of ports for requester 1.
- alu_operator_o  out  `ALU_OP_WIDTH  to ALU operator_i.
- alu_operand_a_o  out  32  to ALU operand_a_i.
- alu_operand_b_o  out  32  to ALU operand_b_i.
- alu_result_i  in  32  from ALU result_o.
- alu_flag_i  in  1  from ALU flag_o.

Behaviour:
- Stage S1 registers: s1_valid, s1_owner, s1_op, s1_a, s1_b.
  - alu_* outputs are driven directly from the S1 registers.
  - When s1_valid=0, alu_* outputs are all zeros.
- Stage S2 registers: s2_valid, s2_owner, s2_result, s2_flag.
- rspN_valid_o = s2_valid & (s2_owner==N).
  - rspN_result_o and rspN_flag_o show s2_result and s2_flag when valid, zero otherwise.
- s2_fire = s2_valid & rsp{s2_owner}_ready_i.
- s1_adv = s1_valid & (!s2_valid | s2_fire).
  - On s1_adv, S2 loads alu_result_i, alu_flag_i and s1_owner, and s2_valid is set to 1.
  - On s2_fire without s1_adv, s2_valid is cleared to 0.
- s1_free = !s1_valid | s1_adv.
- Arbitration (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester selected by ptr is granted.
  - Grant is given only when s1_free=1.
- reqN_ready_o = grant to N. At most one ready is high per cycle.
- On a grant, S1 loads the granted payload and sets s1_valid=1, and ptr moves to the other requester.
  - ptr does not change in cycles with no grant.
- On s1_adv with no grant, s1_valid is cleared to 0.
- Latency: a request accepted at edge t produces rsp_valid high in the cycle after edge t+1 (2 edges).
- Throughput: 1 operation per cycle while responses are consumed immediately.
- Backpressure:
  - When rsp ready is low, S2 holds. S1 fills, then both req readys go low.
  - s2_result and s2_flag stay stable while rsp valid is high and ready is low.
  - The other requester's traffic stalls behind the blocked response (in-order, single path). This is the intended behaviour.
- Requester rules:
  - A requester must hold valid and payload stable until ready.
  - A requester may drop valid before ready; nothing is issued in that case.
- All opcodes are forwarded unchanged. Undefined opcodes return whatever the ALU produces, with no error signalled.
- Reset (rst_i=1 at an edge), including mid-operation:
  - s1_valid=0, s2_valid=0, ptr=RR_RESET_PTR; all data registers cleared to 0.
  - In-flight operations are dropped with no response.
  - All outputs read 0 in the cycle after reset.
- While rst_i is high, both req readys are forced to 0.

Optional Feature:
- Macro MIRISCV_ALU_ARB_STATS_EN.
- Defined: adds output ports grant0_cnt_o[31:0], grant1_cnt_o[31:0] and stall_cnt_o[31:0].
  - grantN_cnt_o increments on each grant to requester N.
  - stall_cnt_o increments in each cycle where some reqN_valid_i=1 and no grant is given.
  - All counters wrap from 0xFFFFFFFF to 0 and reset to 0.
- Not defined: these ports and registers are absent. Behaviour is otherwise identical.

Test Plan:
- Single request:
  - Stimulus: req0 `ALU_ADD, a=5, b=7, rsp0_ready=1.
  - Required: req0_ready high in that cycle; rsp0_valid high in the cycle after the next edge with result=12, flag=0; rsp1_valid stays 0.
- Contention:
  - Stimulus: after reset both valid continuously; req0 `ALU_SUB 10-3, req1 `ALU_LTU a=1, b=2.
  - Required: grants alternate 0,1,0,1; responses in the same order; port 0 result=7 flag=0; port 1 result=1 flag=1.
- Backpressure:
  - Stimulus: rsp0_ready=0 for 5 cycles while req0 issues `ALU_XOR 0xF0^0x0F then `ALU_EQ 3==3.
  - Required: rsp0 holds 0xFF stable; second op waits in S1; req0/req1 ready go low.
  - After ready rises: 0xFF, then result=1 flag=1 on consecutive cycles.
- Cross-owner blocking:
  - Stimulus: port 0 response is pending with rsp0_ready=0, and req1 is valid.
  - Required: req1 is accepted once into S1, then stalls; rsp1 stays 0 until port 0 consumes.
- Reset mid-flight:
  - Stimulus: assert rst_i for 1 cycle while S1 and S2 are both valid.
  - Required: all rsp valids 0 next cycle, no stale responses afterwards; first grant goes to RR_RESET_PTR.
- Stats (with MIRISCV_ALU_ARB_STATS_EN):
  - Stimulus: 3 req0 grants, 2 req1 grants, 4 blocked cycles.
  - Required: counters read 3/2/4.
  - Forcing a counter to 0xFFFFFFFF and granting once reads 0.
